// File: rtl/dmem_pkg.sv
// Shared types, constants and helpers for the data-memory controller.
// DMEM_GPIO_EN (optional) adds the memory-mapped GPIO output register at GPIO_ADDR.
package dmem_pkg;

    localparam int          DEFAULT_DEPTH       = 256;
    localparam int          DEFAULT_WAIT_CYCLES = 0;
    localparam logic [31:0] GPIO_ADDR           = 32'h0000_0400;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_GPIO,
        DEC_ERR
    } dec_e;

    // Address bits [1:0] never change the decode result.
    function automatic dec_e decode(input logic [31:0] addr, input int depth);
        if (addr < 32'(depth * 4)) return DEC_RAM;
`ifdef DMEM_GPIO_EN
        if (addr[31:2] == GPIO_ADDR[31:2]) return DEC_GPIO;
`endif
        return DEC_ERR;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU-side request/response bus of the data-memory controller.
interface dmem_if;

    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_ready, mem_addr, mem_wdata, mem_wstrb,
        input  mem_valid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_ready, mem_addr, mem_wdata, mem_wstrb,
        output mem_valid, mem_rdata, mem_err
    );

endinterface

// File: rtl/dmem_sram.sv
// Single-port synchronous RAM, DEPTH x 32, per-byte write enables, registered read.
import dmem_pkg::*;

module dmem_sram #(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: storage arrays get no reset; clearing them would turn the RAM into flops.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one request at a time, optional wait states, RAM + GPIO decode.
// DMEM_GPIO_EN adds the gpio_out port and its register at GPIO_ADDR.
import dmem_pkg::*;

module dmem_ctrl #(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    dmem_if.slave       bus
`ifdef DMEM_GPIO_EN
    ,
    output logic [31:0] gpio_out
`endif
);

    localparam int AW = $clog2(DEPTH);

    state_e      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        valid_q;
    logic [31:0] rdata_hold;
    logic        err_hold;

    dec_e          dec;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_we;
    logic [31:0]   sram_rdata;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        dec        = decode(addr_q, DEPTH);
        resp_rdata = '0;
        resp_err   = 1'b0;
        case (dec)
            DEC_RAM:  resp_rdata = sram_rdata;
`ifdef DMEM_GPIO_EN
            DEC_GPIO: resp_rdata = gpio_out;
`endif
            default:  resp_err = 1'b1;
        endcase
        // The incoming address drives the RAM while idle so a zero-wait read is ready in RESP.
        sram_addr = (state == IDLE) ? bus.mem_addr[AW+1:2] : addr_q[AW+1:2];
        sram_we   = (state == RESP && dec == DEC_RAM) ? wstrb_q : 4'b0000;
    end

    dmem_sram #(.DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .addr  (sram_addr),
        .we    (sram_we),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            valid_q    <= 1'b0;
            rdata_hold <= '0;
            err_hold   <= 1'b0;
`ifdef DMEM_GPIO_EN
            gpio_out   <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_ready && !valid_q) begin
                        addr_q  <= bus.mem_addr;
                        wdata_q <= bus.mem_wdata;
                        wstrb_q <= bus.mem_wstrb;
                        if (WAIT_CYCLES == 0) begin
                            state   <= RESP;
                            valid_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    rdata_hold <= resp_rdata;
                    err_hold   <= resp_err;
`ifdef DMEM_GPIO_EN
                    if (dec == DEC_GPIO) gpio_out <= merge_bytes(gpio_out, wdata_q, wstrb_q);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response fields are live during RESP and frozen at their last value otherwise.
    assign bus.mem_valid = valid_q;
    assign bus.mem_rdata = valid_q ? resp_rdata : rdata_hold;
    assign bus.mem_err   = valid_q ? resp_err   : err_hold;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a zero-wait instance and a three-wait instance side by side.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic rst_n0;
    logic rst_n3;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    dmem_if b0 ();
    dmem_if b3 ();

`ifdef DMEM_GPIO_EN
    logic [31:0] gpio0;
    logic [31:0] gpio3;
`endif

    dmem_ctrl #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk     (clk),
        .reset_n (rst_n0),
        .bus     (b0)
`ifdef DMEM_GPIO_EN
        ,
        .gpio_out(gpio0)
`endif
    );

    dmem_ctrl #(.DEPTH(256), .WAIT_CYCLES(3)) dut3 (
        .clk     (clk),
        .reset_n (rst_n3),
        .bus     (b3)
`ifdef DMEM_GPIO_EN
        ,
        .gpio_out(gpio3)
`endif
    );

    bit          sel;
    logic        valid_s;
    logic [31:0] rdata_s;
    logic        err_s;

    always_comb begin
        if (sel) begin
            valid_s = b3.mem_valid;
            rdata_s = b3.mem_rdata;
            err_s   = b3.mem_err;
        end else begin
            valid_s = b0.mem_valid;
            rdata_s = b0.mem_rdata;
            err_s   = b0.mem_err;
        end
    end

    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st);
        if (sel) begin
            b3.mem_ready = r; b3.mem_addr = a; b3.mem_wdata = wd; b3.mem_wstrb = st;
        end else begin
            b0.mem_ready = r; b0.mem_addr = a; b0.mem_wdata = wd; b0.mem_wstrb = st;
        end
    endtask

    // One request; lat counts falling edges after the acceptance edge until mem_valid is seen.
    task automatic txn(input bit s, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int drop_at,
                       output logic [31:0] rd, output logic er, output int lat);
        sel = s;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        @(negedge clk);
        drive(1'b1, a, wd, st);
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == drop_at) drive(1'b0, a, wd, st);
            if (valid_s === 1'b1) begin
                lat = n;
                rd  = rdata_s;
                er  = err_s;
                break;
            end
        end
        drive(1'b0, '0, '0, 4'b0000);
    endtask

    task automatic test_reset();
        rst_n0 = 1'b0;
        rst_n3 = 1'b0;
        sel = 1'b0; drive(1'b0, '0, '0, 4'b0000);
        sel = 1'b1; drive(1'b0, '0, '0, 4'b0000);
        repeat (2) @(negedge clk);
        tests_run++;
        if ({b0.mem_valid, b0.mem_err, b0.mem_rdata} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_out0: got v=%b e=%b d=%h want all 0", b0.mem_valid, b0.mem_err, b0.mem_rdata);
        end
        tests_run++;
        if ({b3.mem_valid, b3.mem_err, b3.mem_rdata} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_out3: got v=%b e=%b d=%h want all 0", b3.mem_valid, b3.mem_err, b3.mem_rdata);
        end
`ifdef DMEM_GPIO_EN
        tests_run++;
        if (gpio0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_gpio: got %h want 00000000", gpio0);
        end
`endif
        rst_n0 = 1'b1;
        rst_n3 = 1'b1;
        @(negedge clk);
        tests_run++;
        if (b0.mem_valid !== 1'b0 || b3.mem_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle_valid: got %b/%b want 0/0", b0.mem_valid, b3.mem_valid);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat;
        txn(1'b0, 32'h3FC, 32'h1234_5678, 4'b1111, 0, rd, er, lat);
        tests_run++;
        if (lat !== 1 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_wr: got lat=%0d err=%b want lat=1 err=0", lat, er);
        end
        txn(1'b0, 32'h3FC, 32'h0, 4'b0000, 0, rd, er, lat);
        tests_run++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL basic_rd: got lat=%0d err=%b d=%h want 1 0 12345678", lat, er, rd);
        end
        txn(1'b0, 32'h3FC, 32'hCAFE_F00D, 4'b1111, 0, rd, er, lat);
        tests_run++;
        if (rd !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL read_before_write: got %h want 12345678", rd);
        end
        txn(1'b0, 32'h3FF, 32'h0, 4'b0000, 0, rd, er, lat);
        tests_run++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL top_word_unaligned: got d=%h e=%b want cafef00d 0", rd, er);
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd; logic er; int lat;
        txn(1'b0, 32'h10, 32'hAABB_CCDD, 4'b1111, 0, rd, er, lat);
        txn(1'b0, 32'h11, 32'h0000_1100, 4'b0010, 0, rd, er, lat);
        txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat);
        tests_run++;
        if (rd !== 32'hAABB_11DD) begin
            tests_failed++;
            $display("FAIL byte_strobe: got %h want aabb11dd", rd);
        end
        @(negedge clk);
        tests_run++;
        if (b0.mem_valid !== 1'b0 || b0.mem_rdata !== 32'hAABB_11DD) begin
            tests_failed++;
            $display("FAIL rdata_hold: got v=%b d=%h want 0 aabb11dd", b0.mem_valid, b0.mem_rdata);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        txn(1'b0, 32'h0, 32'h0102_0304, 4'b1111, 0, rd, er, lat);
        txn(1'b0, 32'h800, 32'h0, 4'b0000, 0, rd, er, lat);
        tests_run++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL oor_read: got lat=%0d e=%b d=%h want 1 1 00000000", lat, er, rd);
        end
        @(negedge clk);
        tests_run++;
        if (b0.mem_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_hold: got %b want 1", b0.mem_err);
        end
        txn(1'b0, 32'h800, 32'hDEAD_BEEF, 4'b1111, 0, rd, er, lat);
        tests_run++;
        if (er !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_write_err: got %b want 1", er);
        end
        txn(1'b0, 32'h0, 32'h0, 4'b0000, 0, rd, er, lat);
        tests_run++;
        if (rd !== 32'h0102_0304 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL oor_no_write_w0: got d=%h e=%b want 01020304 0", rd, er);
        end
        txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat);
        tests_run++;
        if (rd !== 32'hAABB_11DD) begin
            tests_failed++;
            $display("FAIL oor_no_write_w4: got %h want aabb11dd", rd);
        end
    endtask

    task automatic test_gpio();
        logic [31:0] rd; logic er; int lat;
        txn(1'b0, 32'h400, 32'h0000_00A5, 4'b0001, 0, rd, er, lat);
`ifdef DMEM_GPIO_EN
        tests_run++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL gpio_write: got e=%b d=%h want 0 00000000", er, rd);
        end
        @(negedge clk);
        tests_run++;
        if (gpio0 !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL gpio_out: got %h want 000000a5", gpio0);
        end
        txn(1'b0, 32'h400, 32'h0, 4'b0000, 0, rd, er, lat);
        tests_run++;
        if (rd !== 32'h0000_00A5 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL gpio_read: got d=%h e=%b want 000000a5 0", rd, er);
        end
`else
        tests_run++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL gpio_absent_err: got e=%b d=%h want 1 00000000", er, rd);
        end
        txn(1'b0, 32'h0, 32'h0, 4'b0000, 0, rd, er, lat);
        tests_run++;
        if (rd !== 32'h0102_0304) begin
            tests_failed++;
            $display("FAIL gpio_absent_no_write: got %h want 01020304", rd);
        end
`endif
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h20, 32'h55AA_55AA, 4'b1111, 0, rd, er, lat);
        tests_run++;
        if (lat !== 4 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_wr_latency: got lat=%0d e=%b want 4 0", lat, er);
        end
        txn(1'b1, 32'h20, 32'h0, 4'b0000, 2, rd, er, lat);
        tests_run++;
        if (lat !== 4 || rd !== 32'h55AA_55AA) begin
            tests_failed++;
            $display("FAIL wait_rd_drop_ready: got lat=%0d d=%h want 4 55aa55aa", lat, rd);
        end
        @(negedge clk);
        tests_run++;
        if (b3.mem_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL valid_one_cycle: got %b want 0", b3.mem_valid);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; int seen;
        txn(1'b1, 32'h40, 32'h1122_3344, 4'b1111, 0, rd, er, lat);
        sel = 1'b1;
        @(negedge clk);
        drive(1'b1, 32'h40, 32'h9999_9999, 4'b1111);
        @(posedge clk);
        repeat (2) @(negedge clk);
        rst_n3 = 1'b0;
        drive(1'b0, '0, '0, 4'b0000);
        #1;
        tests_run++;
        if ({b3.mem_valid, b3.mem_err, b3.mem_rdata} !== 34'd0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got v=%b e=%b d=%h want all 0", b3.mem_valid, b3.mem_err, b3.mem_rdata);
        end
        @(negedge clk);
        rst_n3 = 1'b1;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (b3.mem_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_resp: got %0d valid cycles want 0", seen);
        end
        txn(1'b1, 32'h40, 32'h0, 4'b0000, 0, rd, er, lat);
        tests_run++;
        if (rd !== 32'h1122_3344 || lat !== 4) begin
            tests_failed++;
            $display("FAIL abort_no_commit: got d=%h lat=%0d want 11223344 4", rd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_strobe();
        test_out_of_range();
        test_gpio();
        test_wait_states();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, 256, number of 32-bit RAM words; byte range 0 .. DEPTH*4-1.
REQ-002 Parameter WAIT_CYCLES, 0, extra wait cycles inserted before each response (0..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 mem_ready  input  1  CPU request strobe, held until mem_valid.
REQ-006 mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 mem_wdata  input  32  write data.
REQ-008 mem_wstrb  input  4  byte write enables; 4'b0000 = read.
REQ-009 mem_valid  output  1  one-cycle response pulse.
REQ-010 mem_rdata  output  32  read data, meaningful only while mem_valid=1.
REQ-011 mem_err  output  1  decode error, meaningful only while mem_valid=1.
REQ-012 gpio_out  output  32  memory-mapped output register (present only with DMEM_GPIO_EN).

Function
REQ-013 FSM states: IDLE, WAIT, RESP.
REQ-014 IDLE: request accepted when mem_ready=1 and mem_valid=0; addr/wdata/wstrb latched on that edge.
REQ-015 Acceptance with WAIT_CYCLES=0 -> RESP; otherwise -> WAIT with counter loaded to WAIT_CYCLES.
REQ-016 WAIT: counter decrements each cycle; at 1 -> RESP.
REQ-017 RESP: mem_valid=1 for exactly one cycle, then IDLE unconditionally.
REQ-018 Latency: mem_valid high exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-019 mem_ready in RESP or WAIT is ignored; next acceptance is no earlier than the cycle after RESP; peak rate one transaction per WAIT_CYCLES+2 cycles.
REQ-020 mem_ready dropping during WAIT does not abort; the latched transaction completes.
REQ-021 RAM hit (addr < DEPTH*4): mem_rdata = word content before this write (read-before-write); bytes with wstrb set are written at the RESP edge.
REQ-022 GPIO hit (addr == GPIO_ADDR, 0x0000_0400, macro on): rdata = gpio_out; strobed bytes update gpio_out at the RESP edge.
REQ-023 Any other address: mem_err=1, mem_rdata=0, no state written.
REQ-024 mem_rdata and mem_err hold their last values while mem_valid=0.

Reset
REQ-025 reset_n=0: state IDLE, counter 0, mem_valid 0, mem_rdata 0, mem_err 0, gpio_out 0, latched request cleared.
REQ-026 Reset mid-transaction aborts it; no RAM or GPIO write is committed; no response is issued.
REQ-027 RAM contents are not reset.

Configuration
REQ-028 DMEM_GPIO_EN defined: gpio_out port and register exist; GPIO_ADDR decodes per REQ-022.
REQ-029 DMEM_GPIO_EN undefined: no gpio_out port; GPIO_ADDR decodes as an error per REQ-023.

Structure
REQ-030 Package dmem_pkg holds the FSM state enum, GPIO_ADDR, and default DEPTH/WAIT_CYCLES constants.
REQ-031 Sub-module dmem_sram: synchronous single-port RAM, DEPTH x 32, 4 byte-write enables, registered read; instantiated once.

Verification
REQ-032 WAIT_CYCLES=0: write 0x000003FC data 0x12345678 wstrb 1111, then read 0x3FC -> mem_valid 1 cycle after each acceptance, read returns 0x12345678, mem_err=0.
REQ-033 Byte strobe: word 0x10 = 0xAABBCCDD, write 0x00000011 wstrb 0010 -> readback 0xAABB11DD.
REQ-034 WAIT_CYCLES=3: read at 0x20 -> mem_valid exactly 4 cycles after acceptance; mem_ready dropped at cycle 2 still yields a response.
REQ-035 Out of range: read 0x00000800 -> mem_valid with mem_err=1, rdata=0; write there leaves all RAM unchanged.
REQ-036 DMEM_GPIO_EN: write 0x400 data 0x000000A5 wstrb 0001 -> gpio_out=0x000000A5 after RESP; read 0x400 returns 0x000000A5; without the macro, same write -> mem_err=1.
REQ-037 reset_n pulsed low during WAIT of a write to 0x40 -> no mem_valid, all outputs 0, later read of 0x40 returns pre-write value.
